// File: rtl/spikifier_array.sv
// Multi-channel integrate-and-fire spike encoder: each lane integrates WIN accepted
// samples, compares against a shared threshold, and pulses a spike SPIKE_DELAY cycles later.
module spikifier_lane #(
  parameter int DW         = 12,
  parameter int AW         = 20,
  parameter int GAIN_SHIFT = 0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          acc_en_i,
  input  logic          cmp_i,
  input  logic          mode_i,
  input  logic [DW-1:0] smp_i,
  input  logic [AW-2:0] v_ref_i,
  output logic          fire_o,
  output logic          ovf_o
);
  localparam logic signed [AW:0] MAXV = {2'b00, {(AW-1){1'b1}}};
  localparam logic signed [AW:0] MINV = {2'b11, {(AW-1){1'b0}}};

  logic signed [AW-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic signed [AW:0]   smp_ext, sum;

  // One extra bit of headroom so a single add can never wrap before clamping.
  assign smp_ext = (AW+1)'($signed(smp_i)) <<< GAIN_SHIFT;
  assign sum     = {acc_q[AW-1], acc_q} + smp_ext;
  assign fire_o  = acc_q > $signed({1'b0, v_ref_i});
  assign ovf_o   = ovf_q;

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (acc_en_i) begin
      if (sum > MAXV) begin
        acc_d = {1'b0, {(AW-1){1'b1}}};
        ovf_d = 1'b1;
      end else if (sum < MINV) begin
        acc_d = {1'b1, {(AW-1){1'b0}}};
        ovf_d = 1'b1;
      end else begin
        acc_d = sum[AW-1:0];
      end
    end else if (cmp_i) begin
      if (!mode_i)     acc_d = '0;
      else if (fire_o) acc_d = acc_q - {1'b0, v_ref_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

module spikifier_array #(
  parameter int NCH         = 4,
  parameter int DW          = 12,
  parameter int AW          = 20,
  parameter int GAIN_SHIFT  = 0,
  parameter int WIN         = 4,
  parameter int SPIKE_DELAY = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [NCH*DW-1:0] in_data_i,
  input  logic [AW-2:0]     v_ref_i,
  input  logic              mode_i,
  output logic [NCH-1:0]    spike_o,
  output logic [NCH-1:0]    ovf_o
);
  localparam int WCW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int DCW = (SPIKE_DELAY > 0) ? $clog2(SPIKE_DELAY + 1) : 1;

  typedef enum logic [1:0] {INTEG, COMPARE, FIRE} state_e;

  state_e           state_q, state_d;
  logic [WCW-1:0]   win_q, win_d;
  logic [DCW-1:0]   dly_q, dly_d;
  logic [NCH-1:0]   mask_q, mask_d;
  logic [NCH-1:0]   spike_q, spike_d;
  logic [NCH-1:0]   fire;
  logic             xfer;

  assign in_ready_o = (state_q == INTEG) & ~rst_i;
  assign xfer       = in_valid_i & in_ready_o;
  assign spike_o    = spike_q;

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    spikifier_lane #(.DW(DW), .AW(AW), .GAIN_SHIFT(GAIN_SHIFT)) u_lane (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .acc_en_i(xfer),
      .cmp_i   (state_q == COMPARE),
      .mode_i  (mode_i),
      .smp_i   (in_data_i[g*DW +: DW]),
      .v_ref_i (v_ref_i),
      .fire_o  (fire[g]),
      .ovf_o   (ovf_o[g])
    );
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    dly_d   = dly_q;
    mask_d  = mask_q;
    spike_d = '0;
    case (state_q)
      INTEG: if (xfer) begin
        if (win_q == WCW'(WIN-1)) begin
          win_d   = '0;
          state_d = COMPARE;
        end else begin
          win_d = win_q + 1'b1;
        end
      end
      COMPARE: begin
        mask_d  = fire;
        dly_d   = DCW'(SPIKE_DELAY);
        state_d = FIRE;
      end
      FIRE: begin
        if (dly_q != '0) begin
          dly_d = dly_q - 1'b1;
        end else begin
          spike_d = mask_q;
          state_d = INTEG;
        end
      end
      default: state_d = INTEG;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= INTEG;
      win_q   <= '0;
      dly_q   <= '0;
      mask_q  <= '0;
      spike_q <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      dly_q   <= dly_d;
      mask_q  <= mask_d;
      spike_q <= spike_d;
    end
  end
endmodule

// File: tb/tb_spikifier_array.sv
// Scoreboard bench: a window-level model predicts spike masks and their due cycles;
// a negedge monitor compares in_ready, spike and ovf against the predictions.
module tb_spikifier_array;
  localparam int NCH = 4, DW = 12, AW = 20, GS = 0, WIN = 4, DLY = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [NCH*DW-1:0] in_data = '0;
  logic [AW-2:0]     v_ref = '0;
  logic              mode = 1'b0;
  logic [NCH-1:0]    spike, ovf;

  always #5 clk = ~clk;

  spikifier_array #(.NCH(NCH), .DW(DW), .AW(AW), .GAIN_SHIFT(GS), .WIN(WIN),
                    .SPIKE_DELAY(DLY)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .v_ref_i(v_ref), .mode_i(mode), .spike_o(spike), .ovf_o(ovf)
  );

  typedef struct {int due; logic [NCH-1:0] mask; logic [NCH-1:0] ovf;} exp_t;
  exp_t q[$];

  int tests = 0, fails = 0, cyc = 0;

  // Reference model: windows of WIN accepted samples, clamp arithmetic on longints.
  longint         acc[NCH];
  logic [NCH-1:0] m_ovf = '0;
  int             cnt = 0, rel = 0;
  bit             busy = 0, cmp_pend = 0;

  always @(posedge clk) begin
    longint lo, hi, s;
    logic [NCH-1:0] m;
    exp_t e;
    lo = -(64'sd1 <<< (AW-1));
    hi = (64'sd1 <<< (AW-1)) - 1;
    cyc++;
    if (rst) begin
      for (int i = 0; i < NCH; i++) acc[i] = 0;
      m_ovf = '0; cnt = 0; busy = 0; cmp_pend = 0;
      q.delete();
    end else begin
      if (cmp_pend) begin
        cmp_pend = 0;
        for (int i = 0; i < NCH; i++) begin
          m[i] = acc[i] > longint'(v_ref);
          if (!mode) acc[i] = 0;
          else if (m[i]) acc[i] = acc[i] - longint'(v_ref);
        end
        e.due = cyc + 1 + DLY; e.mask = m; e.ovf = m_ovf;
        q.push_back(e);
      end
      if (busy && cyc == rel) busy = 0;
      else if (!busy && in_valid) begin
        for (int i = 0; i < NCH; i++) begin
          s = acc[i] + (longint'($signed(in_data[i*DW +: DW])) <<< GS);
          if (s > hi) begin s = hi; m_ovf[i] = 1'b1; end
          else if (s < lo) begin s = lo; m_ovf[i] = 1'b1; end
          acc[i] = s;
        end
        cnt++;
        if (cnt == WIN) begin
          cnt = 0; busy = 1; rel = cyc + 2 + DLY; cmp_pend = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    tests++;
    if (in_ready !== (!rst && !busy)) begin
      fails++;
      $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, !rst && !busy);
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      tests++;
      if (spike !== e.mask) begin
        fails++;
        $display("FAIL spike cyc=%0d got=%b exp=%b", cyc, spike, e.mask);
      end
      tests++;
      if (ovf !== e.ovf) begin
        fails++;
        $display("FAIL ovf cyc=%0d got=%b exp=%b", cyc, ovf, e.ovf);
      end
    end else if (spike !== '0) begin
      tests++; fails++;
      $display("FAIL spurious_spike cyc=%0d got=%b exp=0", cyc, spike);
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_in(input bit v, input int d0, input int d1, input int d2, input int d3);
    in_valid = v;
    in_data  = {DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
  endtask

  task automatic send(input int d0, input int d1, input int d2, input int d3);
    int k;
    set_in(1'b1, d0, d1, d2, d3);
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (k == 50) begin
      tests++; fails++;
      $display("FAIL accept_timeout cyc=%0d got=no_ready exp=ready", cyc);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic stream(input int n, input int d0, input int d1, input int d2, input int d3);
    set_in(1'b1, d0, d1, d2, d3);
    cyc_wait(n);
    in_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    in_valid = 1'b0;
    cyc_wait(n);
  endtask

  task automatic do_rst(input int n);
    rst = 1'b1;
    cyc_wait(n);
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    cyc_wait(2);
    @(negedge clk);
    tests++;
    if (spike !== '0 || ovf !== '0) begin
      fails++;
      $display("FAIL reset_outputs got=%b/%b exp=0/0", spike, ovf);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // basic fire, then all-zero window proves the mode-0 clear
    v_ref = 350; mode = 1'b0;
    repeat (4) send(100, 80, 0, 0);
    gap(8);
    repeat (4) send(0, 0, 0, 0);
    gap(8);

    // threshold equality, then one below
    send(0, 0, 100, 0); send(0, 0, 100, 0); send(0, 0, 100, 0); send(0, 0, 50, 0);
    gap(8);
    v_ref = 349;
    send(0, 0, 100, 0); send(0, 0, 100, 0); send(0, 0, 100, 0); send(0, 0, 50, 0);
    gap(8);

    // subtract mode with residuals; valid held through busy phases
    do_rst(1); mode = 1'b1; v_ref = 350;
    stream(100, 100, 10, 0, 0);
    gap(8);

    // saturation both directions at maximum threshold
    do_rst(1); mode = 1'b1; v_ref = '1;
    stream(600, 0, 0, 0, 2047);
    stream(1300, 0, 0, 0, -2048);
    gap(8);

    // handshake gaps inside a window
    do_rst(1); mode = 1'b0; v_ref = 100;
    send(50, 0, 0, 0); gap(3); send(50, 0, 0, 0); gap(1);
    send(50, 0, 0, 0); gap(5); send(50, 0, 0, 0);
    gap(8);

    // reset mid-window, then reset during FIRE
    send(200, 0, 0, 0); send(200, 0, 0, 0);
    do_rst(1);
    send(30, 0, 0, 0); send(30, 0, 0, 0);
    gap(8);
    send(30, 0, 0, 0); send(30, 0, 0, 0);
    gap(8);
    repeat (4) send(200, 0, 0, 0);
    cyc_wait(2);
    do_rst(1);
    gap(8);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      set_in($urandom_range(0, 3) != 0,
             int'($urandom_range(0, 1200)) - 400, int'($urandom_range(0, 1200)) - 400,
             int'($urandom_range(0, 1200)) - 400, int'($urandom_range(0, 1200)) - 400);
      v_ref = AW'($urandom_range(0, 4000)) ;
      mode  = 1'($urandom_range(0, 1));
      rst   = ($urandom_range(0, 99) == 0);
      cyc_wait(1);
    end
    rst = 1'b0;
    gap(20);

    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL pending_spikes got=%0d exp=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
